// File: rtl/dsc_mul_n.sv
// Deterministic stochastic multiplier: exact product of N unsigned W-bit operands via nested unary SNG sweep.
// Latency: 2^(N*W) RUN cycles, or op[N-1]*2^((N-1)*W) with early shutoff; start ignored while busy.
module dsc_mul_n #(
    parameter int SNG_WIDTH     = 8,
    parameter int NUM_INPUTS    = 3,
    parameter int EARLY_SHUTOFF = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  in_bus,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z
);

    localparam int W  = SNG_WIDTH;
    localparam int N  = NUM_INPUTS;
    localparam int ZW = N * W;
    localparam logic [W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    op      [N];
    logic [W-1:0]    cnt     [N];
    logic [W-1:0]    cnt_nxt [N];
    logic [N-1:0]    at_max;
    logic [N-1:0]    cnt_inc;
    logic [N-1:0]    sn;
    logic [N-1:0]    op_zero;
    logic            stream_bit;
    logic            any_zero;
    logic            term;
    logic            accept;
    logic [ZW-1:0]   z_q;

    // Counter i advances only when every faster counter is about to wrap.
    assign cnt_inc[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_sng
            assign at_max[g]  = (cnt[g] == CNT_MAX);
            assign sn[g]      = (cnt[g] < op[g]);
            assign op_zero[g] = (op[g] == '0);
            assign cnt_nxt[g] = cnt[g] + W'(cnt_inc[g]);
        end
        for (g = 1; g < N; g++) begin : g_carry
            assign cnt_inc[g] = &at_max[g-1:0];
        end
    endgenerate

    assign stream_bit = &sn;
    assign any_zero   = |op_zero;

    // Early shutoff: once the slowest counter reaches its operand, every later stream bit is zero.
    assign term = (EARLY_SHUTOFF != 0) ? (any_zero || (cnt_nxt[N-1] == op[N-1]))
                                       : (&at_max);

    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (abort)     state_nxt = S_IDLE;
                else if (term) state_nxt = S_DONE;
            end
            S_DONE: if (start) state_nxt = S_RUN;
            default:           state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
        z    = z_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                op[i]  <= '0;
                cnt[i] <= '0;
            end
            z_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < N; i++) begin
                op[i]  <= in_bus[i*W +: W];
                cnt[i] <= '0;
            end
            z_q <= '0;
        end else if (state == S_RUN) begin
            if (abort) begin
                for (int i = 0; i < N; i++) begin
                    op[i]  <= '0;
                    cnt[i] <= '0;
                end
                z_q <= '0;
            end else begin
                for (int i = 0; i < N; i++) begin
                    cnt[i] <= cnt_nxt[i];
                end
                z_q <= z_q + ZW'(stream_bit);
            end
        end
    end

endmodule

// File: tb/tb_dsc_mul_n.sv
// Bench for dsc_mul_n: three configurations, scoreboard of expected product and run length.
module tb_dsc_mul_n;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // A: N=2 W=4 full sweep
    logic        a_start = 1'b0, a_abort = 1'b0;
    logic [7:0]  a_in = '0;
    logic        a_busy, a_done;
    logic [7:0]  a_z;
    // B: N=3 W=8 early shutoff
    logic        b_start = 1'b0, b_abort = 1'b0;
    logic [23:0] b_in = '0;
    logic        b_busy, b_done;
    logic [23:0] b_z;
    // C: N=2 W=4 early shutoff
    logic        c_start = 1'b0, c_abort = 1'b0;
    logic [7:0]  c_in = '0;
    logic        c_busy, c_done;
    logic [7:0]  c_z;

    dsc_mul_n #(.SNG_WIDTH(4), .NUM_INPUTS(2), .EARLY_SHUTOFF(0)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .abort(a_abort), .in_bus(a_in),
        .busy(a_busy), .done(a_done), .z(a_z));
    dsc_mul_n #(.SNG_WIDTH(8), .NUM_INPUTS(3), .EARLY_SHUTOFF(1)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .in_bus(b_in),
        .busy(b_busy), .done(b_done), .z(b_z));
    dsc_mul_n #(.SNG_WIDTH(4), .NUM_INPUTS(2), .EARLY_SHUTOFF(1)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .abort(c_abort), .in_bus(c_in),
        .busy(c_busy), .done(c_done), .z(c_z));

    int sel = 0;
    logic        cur_busy, cur_done;
    logic [63:0] cur_z;
    always_comb begin
        cur_busy = a_busy;
        cur_done = a_done;
        cur_z    = 64'(a_z);
        case (sel)
            1: begin cur_busy = b_busy; cur_done = b_done; cur_z = 64'(b_z); end
            2: begin cur_busy = c_busy; cur_done = c_done; cur_z = 64'(c_z); end
            default: ;
        endcase
    end

    typedef struct {
        string       tag;
        logic [63:0] z;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit st, input bit ab, input logic [63:0] bus);
        case (sel)
            0: begin a_start = st; a_abort = ab; a_in = bus[7:0];  end
            1: begin b_start = st; b_abort = ab; b_in = bus[23:0]; end
            default: begin c_start = st; c_abort = ab; c_in = bus[7:0]; end
        endcase
    endtask

    task automatic expect_op(input string tag, input logic [63:0] ez, input int el);
        exp_t e;
        e.tag = tag; e.z = ez; e.lat = el;
        exp_q.push_back(e);
    endtask

    // Accept edge E0 happens at the posedge after start is raised; returns at E0+1.
    task automatic launch(input string tag, input logic [63:0] bus);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, bus);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'($urandom));
        check({tag, "_busy_e0"}, 64'(cur_busy), 64'd1);
        check({tag, "_z_e0"},    cur_z,         64'd0);
        check({tag, "_done_e0"}, 64'(cur_done), 64'd0);
    endtask

    task automatic wait_done(input int start_lat, input int limit);
        int   lat;
        exp_t e;
        lat = start_lat;
        while (!cur_done && lat < limit) begin
            @(posedge clk); #1;
            lat++;
        end
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            if (!cur_done) begin
                check({e.tag, "_timeout"}, 64'd0, 64'd1);
            end else begin
                check({e.tag, "_lat"},  64'(lat),      64'(e.lat));
                check({e.tag, "_z"},    cur_z,         e.z);
                check({e.tag, "_busy"}, 64'(cur_busy), 64'd0);
            end
        end
    endtask

    // Partial product of a 15x15 full sweep after a given number of RUN edges.
    function automatic int sweep_bits(input int edges);
        int n;
        n = 0;
        for (int k = 0; k < edges; k++)
            if ((k % 16) < 15 && (k / 16) < 15) n++;
        return n;
    endfunction

    initial begin
        #1;
        check("rst_a_busy", 64'(a_busy), 64'd0);
        check("rst_a_done", 64'(a_done), 64'd0);
        check("rst_a_z",    64'(a_z),    64'd0);
        check("rst_b_z",    64'(b_z),    64'd0);
        check("rst_c_busy", 64'(c_busy), 64'd0);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);

        // T1: full sweep 15*15
        sel = 0;
        expect_op("t1", 64'd225, 256);
        launch("t1", 64'h0000_00FF);
        wait_done(0, 400);

        // T2: 200*100*1 with early shutoff, done held afterwards
        sel = 1;
        expect_op("t2", 64'd20000, 65536);
        launch("t2", {40'd0, 8'd1, 8'd100, 8'd200});
        wait_done(0, 70000);
        repeat (5) @(posedge clk);
        #1;
        check("t2_done_held", 64'(cur_done), 64'd1);
        check("t2_z_held",    cur_z,         64'd20000);

        // T3: zero operand terminates after one edge
        sel = 1;
        expect_op("t3", 64'd0, 1);
        launch("t3", {40'd0, 8'd7, 8'd5, 8'd0});
        wait_done(0, 100);

        // T4: start during RUN is ignored, then restart from DONE
        sel = 2;
        expect_op("t4a", 64'd27, 144);
        launch("t4a", {56'd0, 4'd9, 4'd3});
        repeat (9) @(posedge clk);
        #1 drive(1'b1, 1'b0, {56'd0, 4'd5, 4'd5});
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0);
        wait_done(10, 300);
        expect_op("t4b", 64'd4, 32);
        launch("t4b", {56'd0, 4'd2, 4'd2});
        wait_done(0, 100);

        // T5: abort mid-run, then start+abort together from IDLE
        sel = 0;
        launch("t5", 64'h0000_00FF);
        repeat (99) @(posedge clk);
        #1;
        check("t5_z_e99", cur_z, 64'(sweep_bits(99)));
        drive(1'b0, 1'b1, 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0);
        check("t5_abort_busy", 64'(cur_busy), 64'd0);
        check("t5_abort_done", 64'(cur_done), 64'd0);
        check("t5_abort_z",    cur_z,         64'd0);
        @(posedge clk); #1;
        check("t5_idle_busy", 64'(cur_busy), 64'd0);
        drive(1'b1, 1'b1, 64'h0000_00FF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd0);
        check("t5_sa_busy", 64'(cur_busy), 64'd1);
        expect_op("t5b", 64'd225, 256);
        wait_done(0, 400);

        // T6: async reset between edges mid-run
        sel = 0;
        launch("t6", 64'h0000_00FF);
        repeat (50) @(posedge clk);
        #2;
        check("t6_z_pre", cur_z, 64'(sweep_bits(50)));
        rst = 1'b0;
        #1;
        check("t6_rst_busy", 64'(cur_busy), 64'd0);
        check("t6_rst_done", 64'(cur_done), 64'd0);
        check("t6_rst_z",    cur_z,         64'd0);
        @(negedge clk); rst = 1'b1;
        expect_op("t6b", 64'd1, 256);
        launch("t6b", 64'h0000_0011);
        wait_done(0, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
